// File: rtl/accum_cpu_ctrl_if.sv
// accum_cpu_ctrl_if: memory and ALU bus between the accumulator CPU controller and its RAM/ALU.
// Signals:
//   mem_addr/mem_wdata/mem_cs/mem_we/mem_oe  controller -> RAM
//   mem_rdata                                RAM -> controller, valid the cycle after a read request
//   alu_a/alu_b/alu_sel                      controller -> ALU
//   alu_out                                  ALU -> controller, combinational
// Modports: master = controller side, slave = RAM/ALU side.
interface accum_cpu_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 26,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_cs;
    logic                  mem_we;
    logic                  mem_oe;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [2:0]            alu_sel;
    logic [DATA_WIDTH-1:0] alu_out;

    modport master (
        output mem_addr, mem_wdata, mem_cs, mem_we, mem_oe, alu_a, alu_b, alu_sel,
        input  mem_rdata, alu_out
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_cs, mem_we, mem_oe, alu_a, alu_b, alu_sel,
        output mem_rdata, alu_out
    );
endinterface

// File: rtl/accum_cpu_ctrl.sv
// accum_cpu_ctrl: multicycle fetch/decode/execute sequencer for the 32-bit accumulator CPU.
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   start            one-cycle pulse that leaves IDLE and begins fetching at RESET_PC
//   bus              accum_cpu_ctrl_if.master: RAM control/data and ALU operands/result
//   pc, ir, ac       architectural register taps
//   halted           high once a HALT instruction has executed
//   step_mode, step  only when SINGLE_STEP_EN is defined: hold each fetch until a step pulse
// Instruction word: [31] immediate flag, [30:27] opcode, [26:0] address / zero-extended immediate.
module accum_cpu_ctrl #(
    parameter int unsigned ADDR_WIDTH = 26,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
`ifdef SINGLE_STEP_EN
    input  logic                  step_mode,
    input  logic                  step,
`endif
    accum_cpu_ctrl_if.master      bus,
    output logic [31:0]           pc,
    output logic [DATA_WIDTH-1:0] ir,
    output logic [DATA_WIDTH-1:0] ac,
    output logic                  halted
);
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_FETCH_WAIT, S_DECODE, S_MEM_RD, S_MEM_WAIT, S_EXEC, S_STORE, S_HALTED
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_HALT  = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_STORE = 4'd3;
    localparam logic [3:0] OP_CLEAR = 4'd4;
    localparam logic [3:0] OP_SKIP  = 4'd5;
    localparam logic [3:0] OP_JUMP  = 4'd6;
    localparam logic [3:0] OP_SUB   = 4'd7;
    localparam logic [3:0] OP_AND   = 4'd8;
    localparam logic [3:0] OP_OR    = 4'd9;
    localparam logic [3:0] OP_NOT   = 4'd10;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [DATA_WIDTH-1:0] mbr_q, mbr_d;
    logic [DATA_WIDTH-1:0] ac_q, ac_d;
    logic                  halted_q, halted_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_cs_q, mem_cs_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_oe_q, mem_oe_d;

    logic                  fetch_go;
    logic [3:0]            opcode;
    logic                  imm_flag;
    logic                  is_alu;
    logic                  ac_zero;
    logic                  skip_take;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [DATA_WIDTH-1:0] operand;
    logic [ADDR_WIDTH-1:0] pc_inc;

    // A fetch request is only issued when allowed; in step mode FETCH idles with cs low.
`ifdef SINGLE_STEP_EN
    assign fetch_go = !step_mode || step;
`else
    assign fetch_go = 1'b1;
`endif

    assign opcode    = ir_q[30:27];
    assign imm_flag  = ir_q[31];
    assign is_alu    = opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_OR;
    assign ac_zero   = ac_q == '0;
    assign op_addr   = ir_q[ADDR_WIDTH-1:0];
    assign operand   = DATA_WIDTH'(ir_q[26:0]);
    assign pc_inc    = pc_q + ADDR_WIDTH'(2);
    assign skip_take = (ir_q[11:10] == 2'b00 && ac_q[DATA_WIDTH-1]) ||
                       (ir_q[11:10] == 2'b01 && ac_zero) ||
                       (ir_q[11:10] == 2'b10 && !ac_q[DATA_WIDTH-1] && !ac_zero);

    // ALU steering is decoded straight from registered state/IR so the result is usable in-cycle.
    assign bus.alu_a   = ac_q;
    assign bus.alu_b   = state_q == S_EXEC ? mbr_q : operand;
    assign bus.alu_sel = opcode == OP_SUB ? 3'b010 :
                         opcode == OP_AND ? 3'b000 :
                         opcode == OP_OR  ? 3'b100 : 3'b001;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        mbr_d   = mbr_q;
        ac_d    = ac_q;
        case (state_q)
            S_IDLE:       state_d = start ? S_FETCH : S_IDLE;
            // Leave FETCH only after the cycle in which the read was actually issued.
            S_FETCH:      state_d = mem_cs_q ? S_FETCH_WAIT : S_FETCH;
            S_FETCH_WAIT: begin
                ir_d    = bus.mem_rdata;
                pc_d    = pc_inc;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_FETCH;
                if (imm_flag) begin
                    if (is_alu) ac_d = bus.alu_out;
                end else begin
                    case (opcode)
                        OP_ADD, OP_LOAD, OP_SUB, OP_AND, OP_OR: state_d = S_MEM_RD;
                        OP_STORE: state_d = S_STORE;
                        OP_HALT:  state_d = S_HALTED;
                        OP_CLEAR: ac_d = '0;
                        OP_NOT:   ac_d = ~ac_q;
                        OP_JUMP:  pc_d = op_addr;
                        OP_SKIP:  pc_d = skip_take ? pc_inc : pc_q;
                        default:  ;
                    endcase
                end
            end
            S_MEM_RD:     state_d = S_MEM_WAIT;
            S_MEM_WAIT: begin
                mbr_d   = bus.mem_rdata;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                ac_d    = opcode == OP_LOAD ? mbr_q : bus.alu_out;
                state_d = S_FETCH;
            end
            S_STORE: begin
                mbr_d   = ac_q;
                state_d = S_FETCH;
            end
            S_HALTED:     state_d = S_HALTED;
            default:      state_d = S_IDLE;
        endcase
    end

    // Memory pins are registered from the next state so they are glitch-free and line up
    // with the state they belong to.
    always_comb begin
        halted_d    = state_d == S_HALTED;
        mem_cs_d    = (state_d == S_FETCH && fetch_go) || state_d == S_MEM_RD || state_d == S_STORE;
        mem_we_d    = state_d == S_STORE;
        mem_oe_d    = mem_cs_d && state_d != S_STORE;
        mem_addr_d  = state_d == S_FETCH ? pc_d :
                      (state_d == S_MEM_RD || state_d == S_STORE) ? ir_d[ADDR_WIDTH-1:0] : '0;
        mem_wdata_d = ac_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC[ADDR_WIDTH-1:0];
            ir_q        <= '0;
            mbr_q       <= '0;
            ac_q        <= '0;
            halted_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_oe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            mbr_q       <= mbr_d;
            ac_q        <= ac_d;
            halted_q    <= halted_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_cs_q    <= mem_cs_d;
            mem_we_q    <= mem_we_d;
            mem_oe_q    <= mem_oe_d;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_cs    = mem_cs_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_oe    = mem_oe_q;
    assign pc            = 32'(pc_q);
    assign ir            = ir_q;
    assign ac            = ac_q;
    assign halted        = halted_q;
endmodule

// File: tb/tb_accum_cpu_ctrl.sv
// tb_accum_cpu_ctrl: directed-program bench for accum_cpu_ctrl with a small RAM and ALU model.
module tb_accum_cpu_ctrl;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] ac;
    logic        halted;
    int          checks;
    int          failures;

    logic [31:0] ram [0:1023];
    logic        clr;
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;

    accum_cpu_ctrl_if #(.ADDR_WIDTH(26), .DATA_WIDTH(32)) bus ();

    accum_cpu_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .bus    (bus),
        .pc     (pc),
        .ir     (ir),
        .ac     (ac),
        .halted (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 1024; i++) ram[i] <= '0;
        end else if (ld_en) begin
            ram[ld_addr] <= ld_data;
        end else if (bus.mem_cs && bus.mem_we) begin
            ram[bus.mem_addr[9:0]] <= bus.mem_wdata;
        end
        if (bus.mem_cs && bus.mem_oe) bus.mem_rdata <= ram[bus.mem_addr[9:0]];
    end

    always_comb begin
        bus.alu_out = bus.alu_a + bus.alu_b;
        if (bus.alu_sel == 3'b000) bus.alu_out = bus.alu_a & bus.alu_b;
        if (bus.alu_sel == 3'b010) bus.alu_out = bus.alu_a - bus.alu_b;
        if (bus.alu_sel == 3'b100) bus.alu_out = bus.alu_a | bus.alu_b;
    end

    task automatic begin_prog();
        rst_n = 1'b0;
        start = 1'b0;
        clr   = 1'b1;
        @(negedge clk);
        clr   = 1'b0;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    // Releases reset and pulses start; returns at the negedge of the first FETCH cycle.
    task automatic run();
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (pc !== 32'h100) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h100); end
        checks++; if (ir !== 32'h0) begin failures++; $display("FAIL reset_ir got=%h exp=0", ir); end
        checks++; if (ac !== 32'h0) begin failures++; $display("FAIL reset_ac got=%h exp=0", ac); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
        checks++; if (bus.mem_cs !== 1'b0) begin failures++; $display("FAIL reset_cs got=%b exp=0", bus.mem_cs); end
        checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", bus.mem_we); end
        checks++; if (bus.mem_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", bus.mem_oe); end
        checks++; if (bus.mem_addr !== 26'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus.mem_addr); end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.mem_cs !== 1'b0) begin failures++; $display("FAIL start_in_reset_ignored cs got=%b exp=0", bus.mem_cs); end
        checks++; if (pc !== 32'h100) begin failures++; $display("FAIL idle_pc got=%h exp=%h", pc, 32'h100); end
    endtask

    task automatic test_load_store();
        begin_prog();
        wr(10'h100, 32'h1000011E);
        wr(10'h102, 32'h18000120);
        wr(10'h104, 32'h08000000);
        wr(10'h11E, 32'h7);
        run();
        checks++; if (bus.mem_addr !== 26'h100) begin failures++; $display("FAIL fetch_addr got=%h exp=100", bus.mem_addr); end
        checks++; if ({bus.mem_cs, bus.mem_oe, bus.mem_we} !== 3'b110) begin failures++; $display("FAIL fetch_ctl cs/oe/we got=%b exp=110", {bus.mem_cs, bus.mem_oe, bus.mem_we}); end
        repeat (2) @(negedge clk);
        checks++; if (ir !== 32'h1000011E) begin failures++; $display("FAIL decode_ir got=%h exp=1000011e", ir); end
        checks++; if (pc !== 32'h102) begin failures++; $display("FAIL decode_pc got=%h exp=102", pc); end
        @(negedge clk);
        checks++; if (bus.mem_addr !== 26'h11E || {bus.mem_cs, bus.mem_oe, bus.mem_we} !== 3'b110) begin failures++; $display("FAIL memrd addr=%h ctl=%b exp addr=11e ctl=110", bus.mem_addr, {bus.mem_cs, bus.mem_oe, bus.mem_we}); end
        repeat (3) @(negedge clk);
        checks++; if (ac !== 32'h7) begin failures++; $display("FAIL load_ac got=%h exp=7", ac); end
        checks++; if (bus.mem_addr !== 26'h102) begin failures++; $display("FAIL second_fetch_addr got=%h exp=102", bus.mem_addr); end
        repeat (3) @(negedge clk);
        checks++; if ({bus.mem_cs, bus.mem_oe, bus.mem_we} !== 3'b101) begin failures++; $display("FAIL store_ctl cs/oe/we got=%b exp=101", {bus.mem_cs, bus.mem_oe, bus.mem_we}); end
        checks++; if (bus.mem_addr !== 26'h120 || bus.mem_wdata !== 32'h7) begin failures++; $display("FAIL store_bus addr=%h wdata=%h exp 120/7", bus.mem_addr, bus.mem_wdata); end
        @(negedge clk);
        checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL store_one_cycle we got=%b exp=0", bus.mem_we); end
        checks++; if (pc !== 32'h104) begin failures++; $display("FAIL store_pc got=%h exp=104", pc); end
        checks++; if (ram[10'h120] !== 32'h7) begin failures++; $display("FAIL store_ram got=%h exp=7", ram[10'h120]); end
        for (int i = 0; i < 50 && !halted; i++) @(negedge clk);
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL ls_halt_timeout halted=%b exp=1", halted); end
    endtask

    task automatic test_immediate();
        begin_prog();
        wr(10'h100, 32'h20000000);
        wr(10'h102, 32'h80000009);
        wr(10'h104, 32'hB8000001);
        wr(10'h106, 32'hC8000030);
        wr(10'h108, 32'hC000002F);
        wr(10'h10A, 32'h08000000);
        run();
        repeat (6) @(negedge clk);
        checks++; if (ac !== 32'h9) begin failures++; $display("FAIL addi_ac got=%h exp=9", ac); end
        @(negedge clk);
        checks++; if (bus.mem_cs !== 1'b0) begin failures++; $display("FAIL imm_fw_cs got=%b exp=0", bus.mem_cs); end
        @(negedge clk);
        checks++; if (bus.alu_sel !== 3'b010 || bus.alu_b !== 32'h1) begin failures++; $display("FAIL subi_decode sel=%b b=%h exp 010/1", bus.alu_sel, bus.alu_b); end
        checks++; if (bus.mem_cs !== 1'b0) begin failures++; $display("FAIL imm_decode_cs got=%b exp=0", bus.mem_cs); end
        @(negedge clk);
        checks++; if (ac !== 32'h8) begin failures++; $display("FAIL subi_ac got=%h exp=8", ac); end
        checks++; if (bus.mem_addr !== 26'h106) begin failures++; $display("FAIL imm_next_fetch got=%h exp=106", bus.mem_addr); end
        for (int i = 0; i < 50 && !halted; i++) @(negedge clk);
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL imm_halt_timeout halted=%b exp=1", halted); end
        checks++; if (ac !== 32'h28) begin failures++; $display("FAIL ori_andi_ac got=%h exp=28", ac); end
        checks++; if (pc !== 32'h10C) begin failures++; $display("FAIL imm_halt_pc got=%h exp=10c", pc); end
    endtask

    task automatic test_alu_mem();
        begin_prog();
        wr(10'h100, 32'h10000140);
        wr(10'h102, 32'h00000142);
        wr(10'h104, 32'h38000144);
        wr(10'h106, 32'h40000146);
        wr(10'h108, 32'h48000148);
        wr(10'h10A, 32'h50000000);
        wr(10'h10C, 32'h08000000);
        wr(10'h140, 32'h5);
        wr(10'h142, 32'h3);
        wr(10'h144, 32'hA);
        wr(10'h146, 32'hFF);
        wr(10'h148, 32'h100);
        run();
        repeat (12) @(negedge clk);
        checks++; if (ac !== 32'h8) begin failures++; $display("FAIL mem_add_ac got=%h exp=8", ac); end
        for (int i = 0; i < 100 && !halted; i++) @(negedge clk);
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL alu_halt_timeout halted=%b exp=1", halted); end
        checks++; if (ac !== 32'hFFFFFE01) begin failures++; $display("FAIL alu_chain_ac got=%h exp=fffffe01", ac); end
        checks++; if (pc !== 32'h10E) begin failures++; $display("FAIL alu_halt_pc got=%h exp=10e", pc); end
    endtask

    task automatic test_skip();
        logic [31:0] pre_t  [0:6];
        logic [31:0] skip_t [0:6];
        logic [31:0] exp_t  [0:6];
        pre_t  = '{32'h78000000, 32'h80000001, 32'h50000000, 32'h80000001, 32'h50000000, 32'h50000000, 32'h78000000};
        skip_t = '{32'h28000400, 32'h28000400, 32'h28000000, 32'h28000800, 32'h28000C00, 32'h28000800, 32'h28000000};
        exp_t  = '{32'h118,      32'h116,      32'h118,      32'h118,      32'h116,      32'h116,      32'h116};
        for (int k = 0; k < 7; k++) begin
            begin_prog();
            wr(10'h100, pre_t[k]);
            wr(10'h102, 32'h30000114);
            wr(10'h114, skip_t[k]);
            wr(10'h116, 32'h08000000);
            wr(10'h118, 32'h08000000);
            run();
            repeat (6) @(negedge clk);
            checks++; if (bus.mem_addr !== 26'h114) begin failures++; $display("FAIL skip%0d_jump_fetch got=%h exp=114", k, bus.mem_addr); end
            repeat (3) @(negedge clk);
            checks++; if (pc !== exp_t[k] || 32'(bus.mem_addr) !== exp_t[k]) begin failures++; $display("FAIL skip%0d pc=%h addr=%h exp=%h", k, pc, bus.mem_addr, exp_t[k]); end
        end
    endtask

    task automatic test_jump_halt();
        begin_prog();
        wr(10'h100, 32'h28000000);
        wr(10'h102, 32'h30000108);
        wr(10'h104, 32'h08000000);
        wr(10'h108, 32'hB8000001);
        wr(10'h10A, 32'h30000100);
        run();
        repeat (6) @(negedge clk);
        checks++; if (pc !== 32'h108) begin failures++; $display("FAIL jump_fwd_pc got=%h exp=108", pc); end
        repeat (6) @(negedge clk);
        checks++; if (pc !== 32'h100 || bus.mem_addr !== 26'h100) begin failures++; $display("FAIL jump_back pc=%h addr=%h exp=100", pc, bus.mem_addr); end
        repeat (6) @(negedge clk);
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag got=%b exp=1", halted); end
        checks++; if (pc !== 32'h106) begin failures++; $display("FAIL halt_pc got=%h exp=106", pc); end
        checks++; if (ac !== 32'hFFFFFFFF) begin failures++; $display("FAIL halt_ac got=%h exp=ffffffff", ac); end
        for (int i = 0; i < 20; i++) begin
            start = (i % 4) == 0;
            @(negedge clk);
            checks++; if (bus.mem_cs !== 1'b0 || halted !== 1'b1 || pc !== 32'h106) begin failures++; $display("FAIL halted_hold%0d cs=%b halted=%b pc=%h exp 0/1/106", i, bus.mem_cs, halted, pc); end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid_store();
        begin_prog();
        wr(10'h100, 32'h80000005);
        wr(10'h102, 32'h18000120);
        wr(10'h104, 32'h08000000);
        wr(10'h120, 32'hDEADBEEF);
        run();
        repeat (6) @(negedge clk);
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'h5) begin failures++; $display("FAIL pre_reset_store we=%b wdata=%h exp 1/5", bus.mem_we, bus.mem_wdata); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_we !== 1'b0 || bus.mem_cs !== 1'b0) begin failures++; $display("FAIL async_we_drop we=%b cs=%b exp 0/0", bus.mem_we, bus.mem_cs); end
        checks++; if (ac !== 32'h0 || pc !== 32'h100) begin failures++; $display("FAIL async_regs ac=%h pc=%h exp 0/100", ac, pc); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.mem_cs !== 1'b0) begin failures++; $display("FAIL post_reset_idle cs=%b exp=0", bus.mem_cs); end
        checks++; if (ram[10'h120] !== 32'hDEADBEEF) begin failures++; $display("FAIL no_partial_write got=%h exp=deadbeef", ram[10'h120]); end
    endtask

    initial begin
        clk      = 1'b0;
        rst_n    = 1'b0;
        start    = 1'b0;
        clr      = 1'b0;
        ld_en    = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        checks   = 0;
        failures = 0;
        test_reset();
        test_load_store();
        test_immediate();
        test_alu_mem();
        test_skip();
        test_jump_halt();
        test_reset_mid_store();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
